// File: rtl/md_pkg.sv
// md_pkg: shared encodings, state enum and constants for the multiply/divide sequencer.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_ITER = 32;

    // LO value reported when a divide is attempted with a zero divisor.
    localparam logic [31:0] MD_DZ_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_PREP = 3'd1,
        MD_CALC = 3'd2,
        MD_FIX  = 3'd3,
        MD_DONE = 3'd4
    } md_state_t;

    // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
    function automatic logic [31:0] md_mag(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_step.sv
// md_step: one combinational iteration of the shared engine.
// Multiply: acc[64:32] is the running upper half, acc[31:0] holds the unshifted
// multiplier bits. Divide: acc[63:32] is the remainder, acc[31:0] the quotient.
module md_step
    import md_pkg::*;
(
    input  logic        is_div,
    input  logic [64:0] acc,
    input  logic [31:0] opnd,
    output logic [64:0] acc_next
);

    logic [32:0] sum;
    logic [64:0] shl;
    logic [32:0] diff;

    // Shift-add for multiply, shift then restoring trial subtract for divide.
    always_comb begin
        sum      = {1'b0, acc[63:32]} + {1'b0, opnd};
        shl      = {acc[63:0], 1'b0};
        // The shifted remainder is always below twice the divisor, so the
        // 33-bit difference cannot overflow and diff[32] is its sign.
        diff     = shl[64:32] - {1'b0, opnd};
        acc_next = acc;
        if (is_div) begin
            if (!diff[32]) begin
                acc_next = {1'b0, diff[31:0], shl[31:1], 1'b1};
            end else begin
                acc_next = {1'b0, shl[63:0]};
            end
        end else begin
            if (acc[0]) begin
                acc_next = {1'b0, sum, acc[31:1]};
            end else begin
                acc_next = {1'b0, acc[64:1]};
            end
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: iterative MULT/MULTU/DIV/DIVU engine with PC/regfile stall.
// Optional feature: define MD_EARLY_OUT_EN to finish multiplies as soon as the
// remaining multiplier bits are all zero.
//
// Handshake: a request is start high while ena is high and the sequencer is in
// IDLE; busy then rises in that same cycle and stays high through FIX. done and
// hilo_w pulse together for one enabled cycle in DONE, with hi_out/lo_out valid;
// start seen anywhere but IDLE is dropped, and there is no queueing.
module md_sequencer
    import md_pkg::*;
#(
    parameter int ITER = MD_ITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        hilo_w,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        div_zero,
    output md_state_t   dbg_state
);

    localparam int            CW   = $clog2(ITER) + 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    md_state_t     state;
    md_state_t     state_next;
    logic [CW-1:0] cnt;
    logic          div_q;
    logic          sign_a;
    logic          sign_b;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [31:0]   opnd;
    logic [64:0]   acc;
    logic [64:0]   step_out;
    logic [64:0]   acc_load;
    logic          done_q;
    logic          dz_q;

    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic          neg_q;
    logic [63:0]   prod;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;

`ifdef MD_EARLY_OUT_EN
    logic [CW-1:0] rem_cnt;
    logic [31:0]   rem_mask;
`endif

    assign a_mag = md_mag(a_q, sign_a);
    assign b_mag = md_mag(b_q, sign_b);

    md_step u_step (
        .is_div   (div_q),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (step_out)
    );

    // State register; ena low freezes the sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MD_IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    // Next state and the accumulator value loaded during CALC.
    always_comb begin
        state_next = state;
        acc_load   = step_out;
`ifdef MD_EARLY_OUT_EN
        rem_cnt    = LAST - cnt;
        rem_mask   = (32'h1 << rem_cnt) - 32'h1;
`endif
        case (state)
            MD_IDLE: if (start) state_next = MD_PREP;
            MD_PREP: begin
                state_next = MD_CALC;
`ifdef MD_EARLY_OUT_EN
                if (!div_q && b_mag == 32'h0) state_next = MD_FIX;
`endif
            end
            MD_CALC: begin
                if (cnt == LAST) begin
                    state_next = MD_FIX;
`ifdef MD_EARLY_OUT_EN
                end else if (!div_q && (step_out[31:0] & rem_mask) == 32'h0) begin
                    // Remaining steps would only shift; do them all at once.
                    state_next = MD_FIX;
                    acc_load   = step_out >> rem_cnt;
`endif
                end
            end
            MD_FIX:  state_next = MD_DONE;
            MD_DONE: state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    // Sign fix-up of the finished magnitudes, plus the divide-by-zero override.
    always_comb begin
        neg_q  = sign_a ^ sign_b;
        prod   = neg_q ? (~acc[63:0] + 64'd1) : acc[63:0];
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (div_q) begin
            if (b_q == 32'h0) begin
                res_hi = a_q;
                res_lo = MD_DZ_LO;
            end else begin
                res_lo = md_mag(acc[31:0], neg_q);
                res_hi = md_mag(acc[63:32], sign_a);
            end
        end
    end

    // Operand capture, iteration datapath, counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            div_q  <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            opnd   <= '0;
            acc    <= '0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
        end else if (ena) begin
            done_q <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        div_q  <= op[1];
                        a_q    <= a;
                        b_q    <= b;
                        sign_a <= ~op[0] & a[31];
                        sign_b <= ~op[0] & b[31];
                    end
                end
                MD_PREP: begin
                    cnt <= '0;
                    if (div_q) begin
                        opnd <= b_mag;
                        acc  <= {33'h0, a_mag};
                    end else begin
                        opnd <= a_mag;
                        acc  <= {33'h0, b_mag};
                    end
                end
                MD_CALC: begin
                    cnt <= cnt + CW'(1);
                    acc <= acc_load;
                end
                MD_FIX: begin
                    done_q <= 1'b1;
                    dz_q   <= div_q && (b_q == 32'h0);
                    hi_out <= res_hi;
                    lo_out <= res_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != MD_IDLE && state != MD_DONE) || (state == MD_IDLE && start && ena);
    assign done      = done_q & ena;
    assign hilo_w    = done_q & ena;
    assign div_zero  = dz_q & done_q & ena;
    assign dbg_state = state;

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed bench for md_sequencer with a cycle-level reference model.
module tb_md_sequencer;
    import md_pkg::*;

`ifdef MD_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        hilo_w;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_zero;
    md_state_t   dbg_state;

    int total = 0;
    int bad   = 0;

    // model state: left < 0 idle, left > 0 busy cycles remaining, 0 = DONE cycle
    int          left = -1;
    logic [64:0] exp_q[$];
    logic [31:0] hold_hi = '0;
    logic [31:0] hold_lo = '0;
    logic        cur_dz  = 1'b0;

    md_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hilo_w    (hilo_w),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .div_zero  (div_zero),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference result {div_zero, hi, lo} from plain arithmetic
    function automatic logic [64:0] model_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sp;
        logic [63:0] up;
        int          sx;
        int          sy;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            2'b00: begin
                sp = longint'(sx) * longint'(sy);
                return {1'b0, 64'(sp)};
            end
            2'b01: begin
                up = {32'h0, x} * {32'h0, y};
                return {1'b0, up};
            end
            2'b10: begin
                if (y == 32'h0) return {1'b1, x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
                return {1'b0, 32'(sx % sy), 32'(sx / sy)};
            end
            default: begin
                if (y == 32'h0) return {1'b1, x, 32'hFFFF_FFFF};
                return {1'b0, x % y, x / y};
            end
        endcase
    endfunction

    // reference latency from start cycle to DONE cycle
    function automatic int model_lat(input logic [1:0] o, input logic [31:0] y);
        logic [31:0] m;
        int          msb;
        if (!EARLY || o[1]) return 35;
        m   = (!o[0] && y[31]) ? (~y + 32'd1) : y;
        msb = -1;
        for (int i = 0; i < 32; i++) if (m[i]) msb = i;
        return 3 + msb + 1;
    endfunction

    // compare process: checks outputs mid-cycle, then advances the model to the next edge
    always @(negedge clk) begin
        logic exp_busy;
        logic exp_done;
        logic [64:0] r;
        if (rst) begin
            exp_q.delete();
            left    = -1;
            hold_hi = '0;
            hold_lo = '0;
            cur_dz  = 1'b0;
            chk("rst_busy", 65'(busy), 65'(start && ena));
            chk("rst_done", 65'(done), 65'd0);
            chk("rst_hilo_w", 65'(hilo_w), 65'd0);
            chk("rst_div_zero", 65'(div_zero), 65'd0);
            chk("rst_hi", 65'(hi_out), 65'd0);
            chk("rst_lo", 65'(lo_out), 65'd0);
        end else begin
            exp_busy = (left < 0) ? (start && ena) : (left > 0);
            exp_done = (left == 0) && ena;
            chk("busy", 65'(busy), 65'(exp_busy));
            chk("done", 65'(done), 65'(exp_done));
            chk("hilo_w", 65'(hilo_w), 65'(exp_done));
            chk("div_zero", 65'(div_zero), 65'(exp_done && cur_dz));
            chk("hi_out", 65'(hi_out), 65'(hold_hi));
            chk("lo_out", 65'(lo_out), 65'(hold_lo));
            if (ena) begin
                if (left < 0) begin
                    if (start) begin
                        exp_q.push_back(model_res(op, a, b));
                        left = model_lat(op, b) - 1;
                    end
                end else if (left == 0) begin
                    left = -1;
                end else begin
                    left--;
                    if (left == 0) begin
                        r = exp_q.pop_front();
                        {cur_dz, hold_hi, hold_lo} = r;
                    end
                end
            end
        end
    end

    // one operation; ev: 0 none, 1 second start pulse, 2 ena low 5 cycles, 3 reset pulse
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                          input int lat_plain, input int lat_early, input int ev, input int ev_cyc);
        int n;
        int limit;
        int elat;
        bit seen;
        elat  = EARLY ? lat_early : lat_plain;
        if (ev == 2) elat += 5;
        limit = (ev == 3) ? 45 : 100;
        chk("model_pin", model_res(o, x, y), {edz, ehi, elo});
        @(posedge clk); #2;
        start = 1'b1; op = o; a = x; b = y;
        n = 0;
        seen = 1'b0;
        while (!seen && n < limit) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #2;
                n++;
                if (n == 1) begin
                    start = 1'b0;
                    op = 2'($urandom_range(0, 3));
                    a  = $urandom;
                    b  = $urandom;
                end
                if (ev == 1 && n == ev_cyc)     start = 1'b1;
                if (ev == 1 && n == ev_cyc + 1) start = 1'b0;
                if (ev == 2 && n == ev_cyc)     ena = 1'b0;
                if (ev == 2 && n == ev_cyc + 5) ena = 1'b1;
                if (ev == 3 && n == ev_cyc)     rst = 1'b1;
                if (ev == 3 && n == ev_cyc + 1) rst = 1'b0;
            end
        end
        if (ev == 3) begin
            chk("no_done_after_rst", 65'(seen), 65'd0);
        end else if (!seen) begin
            chk("done_timeout", 65'(n), 65'(elat));
        end else begin
            chk("latency", 65'(n), 65'(elat));
            chk("busy_in_done", 65'(busy), 65'd0);
            chk("hi_lit", 65'(hi_out), 65'(ehi));
            chk("lo_lit", 65'(lo_out), 65'(elo));
            chk("dz_lit", 65'(div_zero), 65'(edz));
        end
    endtask

    // directed sequence
    initial begin
        rst = 1'b1; ena = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset_hi", 65'(hi_out), 65'd0);
        chk("reset_lo", 65'(lo_out), 65'd0);
        chk("reset_busy", 65'(busy), 65'd0);

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 35, 35, 0, 0);
        run_op(MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35, 6, 0, 0);
        run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 35, 35, 0, 0);
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35, 35, 0, 0);
        run_op(MD_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0, 35, 35, 0, 0);
        run_op(MD_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 35, 35, 0, 0);
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 35, 35, 0, 0);
        run_op(MD_MULTU, 32'h0000_1234, 32'h0000_5678, 32'h0000_0000, 32'h0626_0060, 1'b0, 35, 18, 1, 10);
        run_op(MD_DIV,   32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 35, 35, 2, 10);
        run_op(MD_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0, 35, 35, 3, 12);
        run_op(MD_MULTU, 32'h0000_0009, 32'h0000_0001, 32'h0000_0000, 32'h0000_0009, 1'b0, 35, 4, 0, 0);
        run_op(MD_MULT,  32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 35, 3, 0, 0);
        run_op(MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 35, 4, 0, 0);
        run_op(MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, 35, 35, 0, 0);

        repeat (5) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle sequencer for the CPU's multiply/divide resource. It replaces the combinational MUL/DIV paths with a shared iterative shift-add / shift-subtract engine. It accepts MULT, MULTU, DIV and DIVU from the decode/control path and stalls the PC and register file while the engine runs. It delivers HI/LO with a one-cycle write strobe to the HI_LO register.

## Interface
- `ITER`, default 32: iteration count; equals the operand width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `ena` in 1: global enable, same as the CPU `ena`; low freezes all state.
- `start` in 1: request, sampled in IDLE only.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` in 32: Rs value (multiplicand / dividend).
- `b` in 32: Rt value (multiplier / divisor).
- `busy` out 1: stall to PC/regfile; combinational `(state!=IDLE && state!=DONE) || (state==IDLE && start && ena)`.
- `done` out 1: one-cycle completion pulse, registered.
- `hilo_w` out 1: HI and LO write strobe, coincident with `done`.
- `hi_out` out 32: product[63:32] or remainder.
- `lo_out` out 32: product[31:0] or quotient.
- `div_zero` out 1: high with `done` when a DIV/DIVU had `b==0`.

## Operation
- FSM states: IDLE → PREP → CALC → FIX → DONE → IDLE.
- **IDLE:** on `start && ena`, latch `op`, `a`, `b` and the sign flags (`op[0]==0` → signed) → PREP.
- **PREP:** convert operands to magnitudes (two's-complement negate if signed and MSB set); clear accumulator/remainder; iteration counter = 0 → CALC.
- **CALC, multiply:** per cycle, if multiplier LSB is set, add the multiplicand to the upper half of the 65-bit accumulator; shift right 1.
- **CALC, divide (restoring):** shift {rem,quo} left 1; trial subtract of the divisor from rem; if non-negative, keep the result and set the quo LSB.
- **CALC exit:** after `ITER` cycles, counter reaches `ITER-1` → FIX.
- **FIX, multiply:** negate the 64-bit product if sign_a^sign_b (signed ops only).
- **FIX, divide:** quotient negated if sign_a^sign_b; remainder takes the sign of the dividend.
- **DONE:** `hi_out`/`lo_out` valid and held; `done`=`hilo_w`=1 for one cycle → IDLE.
- Results hold in `hi_out`/`lo_out` until the next DONE.
- Divide by zero: HI=`a` (original), LO=0xFFFFFFFF, `div_zero`=1; full latency, no exception.
- Overflow (0x80000000 / -1): LO=0x80000000, HI=0 (natural wrap).
- `start` outside IDLE is ignored; no queueing.
- Operands are sampled only in IDLE; later changes on `a`/`b`/`op` have no effect.

## Timing
- Start accepted at edge E0.
- Fixed latency:
  - PREP: 1 cycle.
  - CALC: 32 cycles.
  - FIX: 1 cycle.
  - DONE: 1 cycle, which is cycle 35 after E0.
- `busy` is high from the start cycle through FIX and low in DONE, so the stalled instruction retires on the edge that writes HI/LO.
- Back-to-back: a new `start` is accepted in the IDLE cycle following DONE.
- `ena`=0: state, counter and datapath hold; `done`/`hilo_w` forced 0; a pending DONE completes when `ena` returns.
- Reset values: state=IDLE; `busy` 0, `done` 0, `hilo_w` 0, `div_zero` 0, `hi_out` 0, `lo_out` 0; counter 0.
- Reset mid-operation aborts immediately; the result is discarded and no `done` is issued.

## Configuration
- `MD_EARLY_OUT_EN` defined: in multiply CALC, when all remaining (unshifted) multiplier bits are 0, align the accumulator by the remaining shift count in one step and go to FIX. Latency becomes 3 + (index of the highest set multiplier magnitude bit + 1) cycles, minimum 3 for multiplier 0. Divide is unaffected.
- `MD_EARLY_OUT_EN` undefined: fixed 35-cycle latency for all ops.

## Structure
- Package `md_pkg` holds:
  - op encodings `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`;
  - state enum;
  - `MD_ITER`=32;
  - the divide-by-zero LO constant 0xFFFFFFFF.
- Sub-module `md_step`: combinational single-iteration datapath (add-shift or subtract-shift selected by op class). The FSM, counter and sign fix-up stay in `md_sequencer`.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `done` exactly 35 cycles after start; `busy` low in the DONE cycle.
- MULT a=-3 b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT a=0x80000000 b=0x80000000 → HI=0x40000000, LO=0.
- DIV a=-7 b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=7 b=2 → LO=3, HI=1.
- DIVU a=5 b=0 → LO=0xFFFFFFFF, HI=5, `div_zero`=1 with `done`; DIV a=0x80000000 b=0xFFFFFFFF → LO=0x80000000, HI=0.
- `start` pulsed again at cycle 10 of an op → ignored, single `done`. `ena` low for 5 cycles mid-CALC → `done` at cycle 40. `rst` at cycle 12 → `busy`=0 immediately, outputs 0, no `done`; the next op completes correctly.
- With `MD_EARLY_OUT_EN`: MULTU a=9 b=1 → HI=0, LO=9, `done` 4 cycles after start.
